// File: rtl/bf_pkg.sv
// Shared definitions for the radix-2 DIF butterfly pipeline.
// Overflow policy is selected with the BF_SAT_EN macro:
//   defined   -> overflowing components clamp to the DW-bit range
//   undefined -> overflowing components wrap (low DW bits kept)
package bf_pkg;

    localparam int BF_DW   = 16;
    localparam int BF_FRAC = 8;

    // Helpers work on one wide signed type so they stay width-agnostic;
    // 64 bits holds the 2*DW+2 combine result for any DW up to 31.
    localparam int BF_XW = 64;
    typedef logic signed [BF_XW-1:0] wide_t;

    // One complex sample at the default word width.
    typedef struct packed {
        logic signed [BF_DW-1:0] re;
        logic signed [BF_DW-1:0] im;
    } cplx_t;

    // floor((x + 2^(k-1)) / 2^k), i.e. round half up; k == 0 passes x through.
    function automatic wide_t round_shift(wide_t x, int k);
        wide_t half;
        if (k == 0) begin
            return x;
        end
        half = wide_t'(1) <<< (k - 1);
        return (x + half) >>> k;
    endfunction

    // True when x is representable as a dw-bit two's complement value.
    function automatic logic fits(wide_t x, int dw);
        wide_t maxv;
        wide_t minv;
        maxv = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
        minv = -(wide_t'(1) <<< (dw - 1));
        return (x <= maxv) && (x >= minv);
    endfunction

    // Reduce x to dw bits (result sign-extended back to wide_t).
    function automatic wide_t requant(wide_t x, int dw);
`ifdef BF_SAT_EN
        wide_t maxv;
        wide_t minv;
        maxv = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
        minv = -(wide_t'(1) <<< (dw - 1));
        if (x > maxv) begin
            return maxv;
        end
        if (x < minv) begin
            return minv;
        end
        return x;
`else
        return (x <<< (BF_XW - dw)) >>> (BF_XW - dw);
`endif
    endfunction

endpackage

// File: rtl/bf_cmul.sv
// Two-stage complex multiplier: registered partial products, then the
// combine into P = D * W at 2*DW+2 bits. Partial products hold while
// stall is high so they stay aligned with the rest of the pipeline.
module bf_cmul
    import bf_pkg::*;
#(
    parameter int DW = BF_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [DW:0]       d_re,
    input  logic [DW:0]       d_im,
    input  logic [DW-1:0]     w_re,
    input  logic [DW-1:0]     w_im,
    output logic [2*DW+1:0]   p_re,
    output logic [2*DW+1:0]   p_im
);

    logic signed [2*DW:0] rr, ii, ri, ir;
    logic signed [2*DW:0] dre_x, dim_x, wre_x, wim_x;

    // Sign-extend operands to the product width so the multiply is exact.
    assign dre_x = $signed({{DW{d_re[DW]}}, d_re});
    assign dim_x = $signed({{DW{d_im[DW]}}, d_im});
    assign wre_x = $signed({{(DW+1){w_re[DW-1]}}, w_re});
    assign wim_x = $signed({{(DW+1){w_im[DW-1]}}, w_im});

    // Register the four partial products unless the stage is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= '0;
            ii <= '0;
            ri <= '0;
            ir <= '0;
        end else if (!stall) begin
            rr <= dre_x * wre_x;
            ii <= dim_x * wim_x;
            ri <= dre_x * wim_x;
            ir <= dim_x * wre_x;
        end
    end

    // Combine into real/imaginary products, one bit wider to absorb the add.
    always_comb begin
        p_re = $signed({rr[2*DW], rr}) - $signed({ii[2*DW], ii});
        p_im = $signed({ri[2*DW], ri}) + $signed({ir[2*DW], ir});
    end

endmodule

// File: rtl/bf_radix2_pipe.sv
// Pipelined radix-2 DIF butterfly: Y0 = A + B, Y1 = (A - B) * W.
// Three stages with valid/ready flow control and bubble squeezing.
// BF_SAT_EN selects clamp (defined) or wrap (undefined) on overflow.
//
// Handshake: a transfer happens on a rising edge where valid && ready on
// that side. Each stage loads when it is empty or its successor loads, so
// in_ready falls in the same cycle out_ready falls with a full pipeline.
module bf_radix2_pipe
    import bf_pkg::*;
#(
    parameter int DW   = BF_DW,
    parameter int FRAC = BF_FRAC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_scale,
    input  logic [DW-1:0] A_re,
    input  logic [DW-1:0] A_im,
    input  logic [DW-1:0] B_re,
    input  logic [DW-1:0] B_im,
    input  logic [DW-1:0] W_re,
    input  logic [DW-1:0] W_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] Y0_re,
    output logic [DW-1:0] Y0_im,
    output logic [DW-1:0] Y1_re,
    output logic [DW-1:0] Y1_im,
    output logic          ovf
);

    logic v1, v2, v3;
    logic ld1, ld2, ld3;

    logic signed [DW:0] s1_re, s1_im, d1_re, d1_im;
    logic [DW-1:0]      w1_re, w1_im;
    logic               sc1;

    logic signed [DW:0] s2_re, s2_im;
    logic               sc2;

    logic [2*DW+1:0]    p_re, p_im;

    wide_t              x_y0r, x_y0i, x_y1r, x_y1i;
    logic [DW-1:0]      n_y0r, n_y0i, n_y1r, n_y1i;
    logic               n_ovf;

    // Load enables ripple back from the output so bubbles get squeezed out.
    assign ld3       = ~v3 | out_ready;
    assign ld2       = ~v2 | ld3;
    assign ld1       = ~v1 | ld2;
    assign in_ready  = ld1;
    assign out_valid = v3;

    // S1: widened sum/difference plus twiddle and scale capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            s1_re <= '0;
            s1_im <= '0;
            d1_re <= '0;
            d1_im <= '0;
            w1_re <= '0;
            w1_im <= '0;
            sc1   <= 1'b0;
        end else if (ld1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_re <= $signed({A_re[DW-1], A_re}) + $signed({B_re[DW-1], B_re});
                s1_im <= $signed({A_im[DW-1], A_im}) + $signed({B_im[DW-1], B_im});
                d1_re <= $signed({A_re[DW-1], A_re}) - $signed({B_re[DW-1], B_re});
                d1_im <= $signed({A_im[DW-1], A_im}) - $signed({B_im[DW-1], B_im});
                w1_re <= W_re;
                w1_im <= W_im;
                sc1   <= in_scale;
            end
        end
    end

    // S2: carry the sum and scale alongside the multiplier's product stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            s2_re <= '0;
            s2_im <= '0;
            sc2   <= 1'b0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                s2_re <= s1_re;
                s2_im <= s1_im;
                sc2   <= sc1;
            end
        end
    end

    bf_cmul #(
        .DW (DW)
    ) u_cmul (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (~ld2),
        .d_re  (d1_re),
        .d_im  (d1_im),
        .w_re  (w1_re),
        .w_im  (w1_im),
        .p_re  (p_re),
        .p_im  (p_im)
    );

    // S3 datapath: round-half-up shift by FRAC (+1 when scaling), then requantise.
    always_comb begin
        x_y0r = round_shift(wide_t'(s2_re), sc2 ? 1 : 0);
        x_y0i = round_shift(wide_t'(s2_im), sc2 ? 1 : 0);
        x_y1r = round_shift(wide_t'($signed(p_re)), sc2 ? FRAC + 1 : FRAC);
        x_y1i = round_shift(wide_t'($signed(p_im)), sc2 ? FRAC + 1 : FRAC);
        n_ovf = ~(fits(x_y0r, DW) & fits(x_y0i, DW) & fits(x_y1r, DW) & fits(x_y1i, DW));
        n_y0r = DW'(requant(x_y0r, DW));
        n_y0i = DW'(requant(x_y0i, DW));
        n_y1r = DW'(requant(x_y1r, DW));
        n_y1i = DW'(requant(x_y1i, DW));
    end

    // S3 registers: outputs hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3    <= 1'b0;
            Y0_re <= '0;
            Y0_im <= '0;
            Y1_re <= '0;
            Y1_im <= '0;
            ovf   <= 1'b0;
        end else if (ld3) begin
            v3 <= v2;
            if (v2) begin
                Y0_re <= n_y0r;
                Y0_im <= n_y0i;
                Y1_re <= n_y1r;
                Y1_im <= n_y1i;
                ovf   <= n_ovf;
            end
        end
    end

endmodule

// File: tb/tb_bf_radix2_pipe.sv
// Self-checking bench for bf_radix2_pipe (honours BF_SAT_EN like the RTL).
module tb_bf_radix2_pipe;
    import bf_pkg::*;

    localparam int DW   = 16;
    localparam int FRAC = 8;
    localparam int EW   = 4*DW + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_scale = 1'b0;
    logic [DW-1:0] A_re = '0, A_im = '0, B_re = '0, B_im = '0, W_re = '0, W_im = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] Y0_re, Y0_im, Y1_re, Y1_im;
    logic          ovf;

    bf_radix2_pipe #(.DW(DW), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_scale  (in_scale),
        .A_re      (A_re),
        .A_im      (A_im),
        .B_re      (B_re),
        .B_im      (B_im),
        .W_re      (W_re),
        .W_im      (W_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y0_re     (Y0_re),
        .Y0_im     (Y0_im),
        .Y1_re     (Y1_re),
        .Y1_im     (Y1_im),
        .ovf       (ovf)
    );

    // ---------------- scoreboard state ----------------
    int             n_checks = 0;
    int             n_fail   = 0;
    longint         cyc      = 0;
    logic [EW-1:0]  exp_q[$];
    longint         t_q[$];
    logic           lat_chk  = 1'b0;
    logic           use_fix  = 1'b0;
    logic [EW-1:0]  fix_exp  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] pack(input int y0r, input int y0i, input int y1r,
                                           input int y1i, input logic o);
        logic [DW-1:0] a, b, c, d;
        a = DW'(y0r);
        b = DW'(y0i);
        c = DW'(y1r);
        d = DW'(y1i);
        return {a, b, c, d, o};
    endfunction

    // Golden model in plain 64-bit integer arithmetic.
    function automatic logic [EW-1:0] model(input cplx_t a, input cplx_t b, input cplx_t w,
                                            input logic sc);
        longint sr, si, dr, di, pr, pi;
        longint y[4];
        logic signed [DW-1:0] t;
        logic o;
        int k;
        sr = longint'($signed(a.re)) + longint'($signed(b.re));
        si = longint'($signed(a.im)) + longint'($signed(b.im));
        dr = longint'($signed(a.re)) - longint'($signed(b.re));
        di = longint'($signed(a.im)) - longint'($signed(b.im));
        pr = dr * longint'($signed(w.re)) - di * longint'($signed(w.im));
        pi = dr * longint'($signed(w.im)) + di * longint'($signed(w.re));
        k  = sc ? FRAC + 1 : FRAC;
        y[0] = sc ? ((sr + 1) >>> 1) : sr;
        y[1] = sc ? ((si + 1) >>> 1) : si;
        y[2] = (pr + (64'sd1 <<< (k - 1))) >>> k;
        y[3] = (pi + (64'sd1 <<< (k - 1))) >>> k;
        o = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (y[i] > 32767 || y[i] < -32768) begin
                o = 1'b1;
`ifdef BF_SAT_EN
                y[i] = (y[i] > 0) ? 32767 : -32768;
`else
                t = y[i][DW-1:0];
                y[i] = t;
`endif
            end
        end
        return pack(int'(y[0]), int'(y[1]), int'(y[2]), int'(y[3]), o);
    endfunction

    // Monitor: check in_ready against occupancy, compare head of queue, push on accept.
    always @(negedge clk) begin
        logic [EW-1:0] obs;
        longint t0;
        cplx_t a, b, w;
        if (rst_n) begin
            check_eq("in_ready", EW'(in_ready), EW'(!(exp_q.size() == 3 && !out_ready)));
            if (out_valid) begin
                obs = {Y0_re, Y0_im, Y1_re, Y1_im, ovf};
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", EW'(1), EW'(0));
                end else begin
                    check_eq("out_data", obs, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        t0 = t_q.pop_front();
                        if (lat_chk) check_eq("latency", EW'(cyc - t0), EW'(3));
                    end
                end
            end
            if (in_valid && in_ready) begin
                a = {A_re, A_im};
                b = {B_re, B_im};
                w = {W_re, W_im};
                exp_q.push_back(use_fix ? fix_exp : model(a, b, w, in_scale));
                t_q.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input cplx_t a, input cplx_t b, input cplx_t w, input logic sc,
                         input logic fix, input logic [EW-1:0] fe);
        int n;
        n = 0;
        in_valid = 1'b1;
        A_re = a.re; A_im = a.im;
        B_re = b.re; B_im = b.im;
        W_re = w.re; W_im = w.im;
        in_scale = sc;
        use_fix = fix;
        fix_exp = fe;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("accept_timeout", EW'(1), EW'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        use_fix  = 1'b0;
    endtask

    task automatic drive_rand(input logic small_w);
        cplx_t a, b, w;
        a.re = DW'($urandom); a.im = DW'($urandom);
        b.re = DW'($urandom); b.im = DW'($urandom);
        if (small_w) begin
            w.re = DW'($urandom_range(512) - 256);
            w.im = DW'($urandom_range(512) - 256);
        end else begin
            w.re = DW'($urandom); w.im = DW'($urandom);
        end
        drive(a, b, w, 1'($urandom_range(1)), 1'b0, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("drain", EW'(exp_q.size()), EW'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_outs"}, {Y0_re, Y0_im, Y1_re, Y1_im, ovf}, '0);
        check_eq({tag, "_valid"}, EW'(out_valid), EW'(0));
    endtask

    // ---------------- main sequence ----------------
    cplx_t ta, tb, tw;
    logic [EW-1:0] e_ovf;

    initial begin
        // Reset and post-reset state
        idle(3);
        check_reset_outputs("in_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check_reset_outputs("after_reset");
        check_eq("after_reset_in_ready", EW'(in_ready), EW'(1));
        idle(2);

        // Directed vectors with hand-derived results
        ta = '{re: -16'sd130, im: -16'sd567};
        tb = '{re: -16'sd770, im: -16'sd392};
        tw = '{re: 16'sd256, im: 16'sd25};
        drive(ta, tb, tw, 1'b0, 1'b1, pack(-900, -959, 657, -112, 1'b0));
        drive(ta, tb, tw, 1'b1, 1'b1, pack(-450, -479, 329, -56, 1'b0));
        ta = '{re: 16'sd32767, im: 16'sd0};
        tw = '{re: 16'sd256, im: 16'sd0};
`ifdef BF_SAT_EN
        e_ovf = pack(32767, 0, 0, 0, 1'b1);
`else
        e_ovf = pack(-2, 0, 0, 0, 1'b1);
`endif
        drive(ta, ta, tw, 1'b0, 1'b1, e_ovf);
        ta = '{re: -16'sd32768, im: -16'sd32768};
        drive(ta, ta, tw, 1'b0, 1'b0, '0);
        drain();

        // Back-to-back stream with out_ready pattern 1,0,0,1 repeating
        fork
            begin
                for (int i = 0; i < 8; i++) drive_rand(1'b1);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    out_ready = (i % 4 == 0) || (i % 4 == 3);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Random 50% input gaps, consumer always ready: fixed 3-cycle latency
        lat_chk = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1) == 1) drive_rand(1'($urandom_range(1)));
            else idle(1);
        end
        drain();
        lat_chk = 1'b0;

        // Reset with three samples in flight
        for (int i = 0; i < 3; i++) drive_rand(1'b1);
        rst_n = 1'b0;
        exp_q.delete();
        t_q.delete();
        #1;
        check_reset_outputs("midrst");
        idle(2);
        rst_n = 1'b1;
        #1;
        check_eq("midrst_in_ready", EW'(in_ready), EW'(1));
        idle(8);
        check_reset_outputs("post_midrst");

        // One more sample after the mid-run reset
        drive_rand(1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
